// File: rtl/frame_window_reader_if.sv
// frame_window_reader_if: window-buffer read port plus windowed-sample output stream.
interface frame_window_reader_if #(parameter int WIDTH = 16);
  logic             wb_valid_i;
  logic [WIDTH-1:0] wb_data_i;
  logic             wb_idle_i;
  logic             wb_rd_en_o;
  logic             start_move_o;
  logic [WIDTH-1:0] out_data_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             out_last_o;
  logic             frame_done_o;
  modport master (
    input  wb_valid_i, wb_data_i, wb_idle_i, out_ready_i,
    output wb_rd_en_o, start_move_o, out_data_o, out_valid_o, out_last_o, frame_done_o
  );
  modport slave (
    output wb_valid_i, wb_data_i, wb_idle_i, out_ready_i,
    input  wb_rd_en_o, start_move_o, out_data_o, out_valid_o, out_last_o, frame_done_o
  );
endinterface

// File: rtl/frame_window_reader.sv
// frame_window_reader: reads a frame from the window buffer, applies the window coefficients, streams the result.
module frame_window_reader #(
  parameter int WIDTH      = 16,
  parameter int COEF_WIDTH = 16,
  parameter int FRAC_BITS  = 15,
  parameter int FRAME_SIZE = 306
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable_i,
  input  logic                          coef_we_i,
  input  logic [$clog2(FRAME_SIZE)-1:0] coef_addr_i,
  input  logic [COEF_WIDTH-1:0]         coef_data_i,
  frame_window_reader_if.master         bus
);
  localparam int AW = $clog2(FRAME_SIZE);
  localparam int PW = WIDTH + COEF_WIDTH;
  localparam logic signed [PW:0] RND  = (PW+1)'(64'sd1 << (FRAC_BITS-1));
  localparam logic signed [PW:0] MAXV = (PW+1)'((64'sd1 << (WIDTH-1)) - 64'sd1);
  localparam logic signed [PW:0] MINV = ~MAXV;
  localparam logic [COEF_WIDTH-1:0] COEF_RST = COEF_WIDTH'((64'sd1 << FRAC_BITS) - 64'sd1);
  typedef enum logic [2:0] {WAIT, READ, DRAIN, MOVE, HOLD} state_t;
  state_t                      state_q;
  logic [AW-1:0]               cnt_q;
  logic signed [COEF_WIDTH-1:0] coef_q [FRAME_SIZE];
  logic signed [PW-1:0]        prod_q;
  logic                        p_valid_q, p_last_q, out_valid_q, out_last_q, start_move_q;
  logic [WIDTH-1:0]            out_data_q, sat_d;
  logic signed [PW:0]          sum_d, rnd_d;
  logic                        en, accept, last_smp;
  assign en       = !out_valid_q || bus.out_ready_i;
  assign accept   = bus.wb_rd_en_o && bus.wb_valid_i;
  assign last_smp = cnt_q == AW'(FRAME_SIZE-1);
  assign bus.wb_rd_en_o   = (state_q == READ) && en;
  assign bus.start_move_o = start_move_q;
  assign bus.out_data_o   = out_data_q;
  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_last_o   = out_last_q;
  assign bus.frame_done_o = out_valid_q && bus.out_ready_i && out_last_q;
  // Round half toward +inf, then clamp to the signed output range.
  always_comb begin
    sum_d = {prod_q[PW-1], prod_q} + RND;
    rnd_d = sum_d >>> FRAC_BITS;
    sat_d = rnd_d > MAXV ? WIDTH'(MAXV) : rnd_d < MINV ? WIDTH'(MINV) : rnd_d[WIDTH-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT;
      cnt_q        <= '0;
      start_move_q <= 1'b0;
    end else begin
      case (state_q)
        WAIT: if (enable_i) begin
          state_q <= READ;
          cnt_q   <= '0;
        end
        READ: if (accept) begin
          cnt_q <= last_smp ? '0 : cnt_q + AW'(1);
          if (last_smp) state_q <= DRAIN;
        end
        DRAIN: if (!p_valid_q && !out_valid_q && bus.wb_idle_i) begin
          state_q      <= MOVE;
          start_move_q <= 1'b1;
        end
        MOVE: begin
          state_q      <= HOLD;
          start_move_q <= 1'b0;
        end
        default: state_q <= WAIT;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FRAME_SIZE; i++) coef_q[i] <= COEF_RST;
      prod_q      <= '0;
      p_valid_q   <= 1'b0;
      p_last_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (coef_we_i && ({1'b0, coef_addr_i} < (AW+1)'(FRAME_SIZE))) coef_q[coef_addr_i] <= coef_data_i;
      if (en) begin
        p_valid_q <= accept;
        if (accept) begin
          prod_q   <= PW'($signed(bus.wb_data_i)) * PW'(coef_q[cnt_q]);
          p_last_q <= last_smp;
        end
        out_valid_q <= p_valid_q;
        out_last_q  <= p_valid_q && p_last_q;
        if (p_valid_q) out_data_q <= sat_d;
      end
    end
  end
endmodule

// File: tb/tb_frame_window_reader.sv
// tb_frame_window_reader: directed vector frames plus reset, backpressure and valid-gap sequences.
module tb_frame_window_reader;
  localparam int FS = 8;
  typedef struct {logic [15:0] smp; logic [15:0] coef; logic [15:0] exp;} vec_t;
  vec_t        tab [16];
  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, coef_we = 1'b0, rp_clr = 1'b1;
  logic [2:0]  coef_addr = '0;
  logic [15:0] coef_data = '0;
  logic [15:0] fsmp [FS];
  logic [15:0] fexp [FS];
  logic [3:0]  rp = '0;
  logic [15:0] got_d [256];
  logic        got_l [256];
  int          got_t [256];
  int          acc_t [256];
  int          cyc = 0, widx = 0, acc_cnt = 0, fd_cnt = 0, sm_cnt = 0, viol = 0;
  int          n_pass = 0, n_tot = 0;
  logic        prev_stall = 1'b0, pl = 1'b0;
  logic [15:0] pd = '0;
  frame_window_reader_if #(.WIDTH(16)) bus ();
  frame_window_reader #(.WIDTH(16), .COEF_WIDTH(16), .FRAC_BITS(15), .FRAME_SIZE(FS)) dut (
    .clk(clk), .rst_n(rst_n), .enable_i(enable), .coef_we_i(coef_we),
    .coef_addr_i(coef_addr), .coef_data_i(coef_data), .bus(bus)
  );
  always #5 clk = ~clk;
  assign bus.wb_data_i = fsmp[rp[2:0]];
  always @(posedge clk) rp <= rp_clr ? 4'd0 : (bus.wb_rd_en_o && bus.wb_valid_i) ? rp + 4'd1 : rp;
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (bus.wb_rd_en_o && bus.wb_valid_i) begin
      acc_t[acc_cnt & 255] = cyc;
      acc_cnt = acc_cnt + 1;
    end
    if (bus.out_valid_o && bus.out_ready_i) begin
      got_d[widx & 255] = bus.out_data_o;
      got_l[widx & 255] = bus.out_last_o;
      got_t[widx & 255] = cyc;
      widx = widx + 1;
    end
    if (bus.frame_done_o) fd_cnt = fd_cnt + 1;
    if (bus.frame_done_o != (bus.out_valid_o && bus.out_ready_i && bus.out_last_o)) viol = viol + 1;
    if (bus.start_move_o) begin
      sm_cnt = sm_cnt + 1;
      if (!bus.wb_idle_i) viol = viol + 1;
    end
    if (prev_stall && rst_n && (bus.out_data_o != pd || bus.out_last_o != pl)) viol = viol + 1;
    if (bus.out_valid_o && !bus.out_ready_i && bus.wb_rd_en_o) viol = viol + 1;
    prev_stall = bus.out_valid_o && !bus.out_ready_i;
    pd = bus.out_data_o;
    pl = bus.out_last_o;
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h want %h", nm, got, exp);
  endtask
  task automatic load_coefs(input int base);
    for (int i = 0; i < FS; i++) begin
      coef_we = 1'b1; coef_addr = 3'(i); coef_data = tab[base+i].coef;
      @(posedge clk); #1;
    end
    coef_we = 1'b0;
  endtask
  task automatic start_frame();
    rp_clr = 1'b1; @(posedge clk); #1 rp_clr = 1'b0;
    enable = 1'b1; @(posedge clk); #1 enable = 1'b0;
  endtask
  task automatic do_frame(input string nm, input bit tog, input bit stall, input bit timing);
    int w0 = widx, a0 = acc_cnt, f0 = fd_cnt, s0 = sm_cnt, bad = 0, k = 0, idle_k = 0;
    bus.wb_idle_i = 1'b0;
    start_frame();
    while (sm_cnt == s0 && k < 100) begin
      bus.wb_valid_i  = tog ? k[0] : 1'b1;
      bus.out_ready_i = !(stall && k >= 5 && k < 10);
      if (widx - w0 >= FS) idle_k++;
      bus.wb_idle_i = idle_k > 3;
      #1;
      if (acc_cnt - a0 >= FS && bus.wb_rd_en_o) bad++;
      @(posedge clk); #1; k++;
    end
    bus.wb_valid_i = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      if (bus.wb_rd_en_o) bad++;
      @(posedge clk); #1;
    end
    chk({nm, "_no_timeout"}, 32'(k < 100), 32'd1);
    chk({nm, "_outputs"}, 32'(widx - w0), 32'(FS));
    chk({nm, "_accepts"}, 32'(acc_cnt - a0), 32'(FS));
    chk({nm, "_frame_done"}, 32'(fd_cnt - f0), 32'd1);
    chk({nm, "_start_move"}, 32'(sm_cnt - s0), 32'd1);
    chk({nm, "_rd_after_frame"}, 32'(bad), 32'd0);
    for (int i = 0; i < FS; i++) begin
      chk($sformatf("%s_data%0d", nm, i), 32'(got_d[(w0+i) & 255]), 32'(fexp[i]));
      chk($sformatf("%s_last%0d", nm, i), 32'(got_l[(w0+i) & 255]), 32'(i == FS-1));
    end
    if (timing) begin
      chk({nm, "_latency"}, 32'(got_t[w0 & 255] - acc_t[a0 & 255]), 32'd2);
      chk({nm, "_throughput"}, 32'(got_t[(w0+FS-1) & 255] - got_t[w0 & 255]), 32'(FS-1));
    end
    bus.out_ready_i = 1'b1;
  endtask
  initial begin
    int w0, k;
    tab[0]  = '{16'h0064, 16'h4000, 16'h0032};
    tab[1]  = '{16'hFF9C, 16'h4000, 16'hFFCE};
    tab[2]  = '{16'hFFFF, 16'h4000, 16'h0000};
    tab[3]  = '{16'h0001, 16'h4000, 16'h0001};
    tab[4]  = '{16'h8000, 16'h8000, 16'h7FFF};
    tab[5]  = '{16'h7FFF, 16'h8000, 16'h8001};
    tab[6]  = '{16'h4000, 16'h7FFF, 16'h4000};
    tab[7]  = '{16'h8000, 16'h7FFF, 16'h8001};
    tab[8]  = '{16'h7FFF, 16'h7FFF, 16'h7FFE};
    tab[9]  = '{16'h1234, 16'h0000, 16'h0000};
    tab[10] = '{16'h0003, 16'h2000, 16'h0001};
    tab[11] = '{16'hFFFD, 16'h2000, 16'hFFFF};
    tab[12] = '{16'h0100, 16'hC000, 16'hFF80};
    tab[13] = '{16'h8000, 16'h0001, 16'hFFFF};
    tab[14] = '{16'h7FFF, 16'hFFFF, 16'hFFFF};
    tab[15] = '{16'h0002, 16'h7FFF, 16'h0002};
    for (int i = 0; i < FS; i++) begin fsmp[i] = 16'h4000; fexp[i] = 16'h4000; end
    bus.wb_valid_i = 1'b1; bus.wb_idle_i = 1'b1; bus.out_ready_i = 1'b1;
    #12;
    chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_out_data", 32'(bus.out_data_o), 32'd0);
    chk("rst_out_last", 32'(bus.out_last_o), 32'd0);
    chk("rst_frame_done", 32'(bus.frame_done_o), 32'd0);
    chk("rst_start_move", 32'(bus.start_move_o), 32'd0);
    chk("rst_rd_en", 32'(bus.wb_rd_en_o), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #2;
    chk("wait_rd_en", 32'(bus.wb_rd_en_o), 32'd0);
    #1 do_frame("dflt", 1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < FS; i++) begin fsmp[i] = tab[f*FS+i].smp; fexp[i] = tab[f*FS+i].exp; end
      load_coefs(f*FS);
      do_frame(f == 0 ? "tab_stall" : "tab_toggle", f == 1, f == 0, 1'b0);
    end
    for (int i = 0; i < FS; i++) begin fsmp[i] = 16'h4000; fexp[i] = 16'h4000; end
    w0 = widx; k = 0;
    bus.wb_idle_i = 1'b0;
    start_frame();
    while (widx - w0 < 3 && k < 50) begin @(posedge clk); #1; k++; end
    #1;
    chk("midrst_pre_valid", 32'(bus.out_valid_o), 32'd1);
    rst_n = 1'b0; #1;
    chk("midrst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("midrst_out_data", 32'(bus.out_data_o), 32'd0);
    chk("midrst_out_last", 32'(bus.out_last_o), 32'd0);
    chk("midrst_rd_en", 32'(bus.wb_rd_en_o), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    do_frame("post_rst", 1'b0, 1'b0, 1'b0);
    chk("monitor_violations", 32'(viol), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
